// File: rtl/skullfet_sequencer_if.sv
// Bundle of firmware control/status and inverter stimulus/response signals for skullfet_sequencer.
// Optional failure-capture signals are present when SKULLFET_SEQ_CAPTURE_EN is defined.
interface skullfet_sequencer_if #(
  parameter int NUM_CH = 3,
  parameter int ITER_W = 16,
  parameter int ERR_W  = 8
);
  logic              start;
  logic              abort;
  logic [ITER_W-1:0] num_iter;
  logic [NUM_CH-1:0] dut_a;
  logic [NUM_CH-1:0] dut_y;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [NUM_CH-1:0] err_mask;
  logic [ITER_W-1:0] iter_count;
`ifdef SKULLFET_SEQ_CAPTURE_EN
  logic              ff_valid;
  logic [ITER_W-1:0] ff_iter;
  logic              ff_phase;
  logic [NUM_CH-1:0] ff_vec;

  modport master (
    output start, abort, num_iter, dut_y,
    input  dut_a, busy, done, pass, err_count, err_mask, iter_count,
    input  ff_valid, ff_iter, ff_phase, ff_vec
  );
  modport slave (
    input  start, abort, num_iter, dut_y,
    output dut_a, busy, done, pass, err_count, err_mask, iter_count,
    output ff_valid, ff_iter, ff_phase, ff_vec
  );
`else
  modport master (
    output start, abort, num_iter, dut_y,
    input  dut_a, busy, done, pass, err_count, err_mask, iter_count
  );
  modport slave (
    input  start, abort, num_iter, dut_y,
    output dut_a, busy, done, pass, err_count, err_mask, iter_count
  );
`endif
endinterface

// File: rtl/skullfet_sequencer.sv
// Walking-one / complement self-test sequencer for the SkullFET inverter channels.
// Define SKULLFET_SEQ_CAPTURE_EN to add first-failure capture (ff_valid/ff_iter/ff_phase/ff_vec).
module skullfet_sequencer #(
  parameter int NUM_CH        = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int ITER_W        = 16,
  parameter int ERR_W         = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  skullfet_sequencer_if.slave   bus
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE} state_t;

  state_t            r_state;
  logic [NUM_CH-1:0] r_sync;
  logic [NUM_CH-1:0] r_ys;
  logic [CNT_W-1:0]  r_settle;
  logic              r_phase;
  logic [ITER_W-1:0] r_num_iter;
  logic [ITER_W-1:0] r_iter;
  logic [NUM_CH-1:0] r_walk;
  logic [NUM_CH-1:0] r_dut_a;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [ERR_W-1:0]  r_err_count;
  logic [NUM_CH-1:0] r_err_mask;
`ifdef SKULLFET_SEQ_CAPTURE_EN
  logic              r_ff_valid;
  logic [ITER_W-1:0] r_ff_iter;
  logic              r_ff_phase;
  logic [NUM_CH-1:0] r_ff_vec;
`endif

  logic [NUM_CH-1:0] w_mism;
  logic              w_last;
  logic [NUM_CH-1:0] w_walk_next;
  logic [ERR_W-1:0]  w_err_inc;

  assign w_mism      = r_ys ^ ~r_dut_a;
  assign w_last      = (r_iter == r_num_iter - ITER_W'(1));
  // One-hot rotated per iteration instead of computing iter_count mod NUM_CH
  assign w_walk_next = {r_walk[NUM_CH-2:0], r_walk[NUM_CH-1]};
  assign w_err_inc   = (r_err_count == '1) ? r_err_count : r_err_count + ERR_W'(1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_sync      <= '0;
      r_ys        <= '0;
      r_settle    <= '0;
      r_phase     <= 1'b0;
      r_num_iter  <= '0;
      r_iter      <= '0;
      r_walk      <= '0;
      r_dut_a     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_err_mask  <= '0;
`ifdef SKULLFET_SEQ_CAPTURE_EN
      r_ff_valid  <= 1'b0;
      r_ff_iter   <= '0;
      r_ff_phase  <= 1'b0;
      r_ff_vec    <= '0;
`endif
    end else begin
      r_sync <= bus.dut_y;
      r_ys   <= r_sync;
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.start && !bus.abort && bus.num_iter != '0) begin
          r_state     <= S_DRIVE;
          r_busy      <= 1'b1;
          r_pass      <= 1'b0;
          r_err_count <= '0;
          r_err_mask  <= '0;
          r_iter      <= '0;
          r_phase     <= 1'b0;
          r_num_iter  <= bus.num_iter;
          r_walk      <= NUM_CH'(1);
          r_dut_a     <= NUM_CH'(1);
`ifdef SKULLFET_SEQ_CAPTURE_EN
          r_ff_valid  <= 1'b0;
          r_ff_iter   <= '0;
          r_ff_phase  <= 1'b0;
          r_ff_vec    <= '0;
`endif
        end
      end else if (bus.abort) begin
        r_state <= S_IDLE;
        r_dut_a <= '0;
        r_busy  <= 1'b0;
        r_pass  <= 1'b0;
      end else begin
        case (r_state)
          S_DRIVE: begin
            r_state  <= S_SETTLE;
            r_settle <= CNT_W'(SETTLE_CYCLES - 1);
          end
          S_SETTLE: begin
            if (r_settle == '0) r_state <= S_SAMPLE;
            else                r_settle <= r_settle - CNT_W'(1);
          end
          S_SAMPLE: begin
            if (w_mism != '0) begin
              r_err_count <= w_err_inc;
              r_err_mask  <= r_err_mask | w_mism;
`ifdef SKULLFET_SEQ_CAPTURE_EN
              if (!r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_iter  <= r_iter;
                r_ff_phase <= r_phase;
                r_ff_vec   <= w_mism;
              end
`endif
            end
            if (!r_phase) begin
              r_phase <= 1'b1;
              r_dut_a <= ~r_walk;
              r_state <= S_DRIVE;
            end else if (!w_last) begin
              r_iter  <= r_iter + ITER_W'(1);
              r_phase <= 1'b0;
              r_walk  <= w_walk_next;
              r_dut_a <= w_walk_next;
              r_state <= S_DRIVE;
            end else begin
              // Final verdict folds in this last comparison
              r_state <= S_IDLE;
              r_dut_a <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (r_err_count == '0) && (w_mism == '0);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.dut_a      = r_dut_a;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.err_count  = r_err_count;
  assign bus.err_mask   = r_err_mask;
  assign bus.iter_count = r_iter;
`ifdef SKULLFET_SEQ_CAPTURE_EN
  assign bus.ff_valid   = r_ff_valid;
  assign bus.ff_iter    = r_ff_iter;
  assign bus.ff_phase   = r_ff_phase;
  assign bus.ff_vec     = r_ff_vec;
`endif
endmodule
